sequential_right_shifter: RTL
=============================

# sequential_right_shifter

Multi-cycle right shifter for the KGP-RISC execute stage. It performs logical (SRL) and arithmetic (SRA) right shifts of a 32-bit operand by a 5-bit amount, one bit position per clock. It pairs with the combinational left shifter in the ALU shift path. A start/busy/done handshake lets the control unit stall while a shift is in progress.

## Interface
- WIDTH, 32, operand and result width in bits
- SHW, 5, shift-amount width; equals log2(WIDTH)

- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  request pulse; sampled only in IDLE or DONE
- IN  input  WIDTH  operand; sampled on the edge that accepts START
- SHAMT  input  SHW  shift amount; sampled with IN
- ARITH  input  1  mode: 1 = SRA (sign fill), 0 = SRL (zero fill); sampled with IN
- BUSY  output  1  high while in SHIFT state
- DONE  output  1  one-cycle pulse, high for the whole DONE state
- OUT  output  WIDTH  result register; updated only on entry to DONE

## Operation
- Internal registers:
  - data register DREG[WIDTH-1:0]
  - counter CNT[SHW-1:0]
  - mode bit MODE
  - FSM state
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - START=1: load DREG=IN, CNT=SHAMT, MODE=ARITH; go to SHIFT.
  - START=0: stay in IDLE.
- SHIFT:
  - CNT!=0: DREG = {fill, DREG[WIDTH-1:1]}; CNT = CNT-1; stay in SHIFT.
  - fill bit: DREG[WIDTH-1] when MODE=1, otherwise 0.
  - CNT==0: OUT = DREG; go to DONE.
  - START is ignored in SHIFT. A request raised in SHIFT is dropped, not queued.
- DONE:
  - DONE=1 for this single cycle.
  - START=1: load as in IDLE and go to SHIFT (back-to-back operation).
  - START=0: go to IDLE.
- OUT keeps its value through IDLE and through any following SHIFT until the next entry to DONE.
- The sign bit for SRA is taken from the live DREG MSB, which stays constant during SRA. The result therefore equals $signed(IN) >>> SHAMT.
- Arithmetic is unsigned on CNT. CNT never wraps because decrement only happens when CNT!=0.
- Reset (RST_N=0, at any time including mid-SHIFT): immediately clear state to IDLE, DREG=0, CNT=0, MODE=0, OUT=0. Outputs go to BUSY=0, DONE=0. The operation in progress is abandoned; no DONE is produced for it.

## Timing
- Edge E0 is the edge that accepts START. BUSY is high from E0 through edge E(SHAMT+1).
- Latency, measured from E0 to the cycle in which DONE is high: SHAMT+1 edges.
  - DONE is high between E(SHAMT+1) and E(SHAMT+2).
  - OUT is valid from E(SHAMT+1).
- Range: SHAMT=0 gives DONE one cycle after acceptance; SHAMT=31 gives DONE 32 cycles after acceptance.
- Throughput with back-to-back requests accepted in DONE: one result per SHAMT+2 cycles.
- BUSY and DONE are Moore outputs decoded from the state register; they are never high together.
- After RST_N deasserts, the first START can be accepted on the first rising edge.

## Test plan
- SRL: START with IN=0xF000_0000, SHAMT=4, ARITH=0.
  - OUT=0x0F00_0000.
  - DONE high exactly 5 edges after acceptance.
  - BUSY high for 5 cycles.
- SRA: IN=0x8000_0000, SHAMT=31, ARITH=1, then IN=0x7FFF_FFFF, SHAMT=31, ARITH=1.
  - First result: OUT=0xFFFF_FFFF, DONE 32 edges after acceptance.
  - Second result: OUT=0x0000_0000.
- Zero shift: IN=0xDEAD_BEEF, SHAMT=0, ARITH=1.
  - OUT=0xDEAD_BEEF.
  - DONE high one cycle after acceptance; BUSY high for 1 cycle.
- START ignored while busy: issue SHAMT=8, IN=0x0000_FF00, ARITH=0; pulse START with IN=0xFFFF_FFFF during SHIFT.
  - OUT=0x0000_00FF.
  - Exactly one DONE pulse.
- Back-to-back: hold START=1 during the DONE cycle of the first request with IN=0x8000_0000, SHAMT=1, ARITH=1.
  - First OUT=0x0000_00FF.
  - Second OUT=0xC000_0000; DONE 2 edges after the DONE-cycle edge.
  - No IDLE cycle between the two operations.
- Reset mid-operation: assert RST_N=0 asynchronously, between edges, during SHIFT with CNT=10.
  - OUT=0, BUSY=0, DONE=0 immediately.
  - After release, no DONE appears until a new START.
  - A new request with SHAMT=2 completes normally.

Source files
------------

// File: rtl/sequential_right_shifter.sv
// Multi-cycle SRL/SRA unit: shifts a WIDTH-bit operand right one position per clock.
// Handshake: START is accepted only in IDLE or DONE; BUSY marks SHIFT; DONE is a one-cycle pulse.
module sequential_right_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] IN,
  input  logic [SHW-1:0]   SHAMT,
  input  logic             ARITH,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] OUT,
  output logic [1:0]       STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dreg, dreg_next;
  logic [SHW-1:0]   cnt, cnt_next;
  logic             mode, mode_next;
  logic [WIDTH-1:0] out_q, out_next;
  logic             fill;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      dreg  <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      out_q <= '0;
    end else begin
      state <= state_next;
      dreg  <= dreg_next;
      cnt   <= cnt_next;
      mode  <= mode_next;
      out_q <= out_next;
    end
  end

  // The MSB never changes during SRA, so using the live MSB as fill replicates the sign.
  assign fill = mode ? dreg[WIDTH-1] : 1'b0;

  always_comb begin
    state_next = state;
    dreg_next  = dreg;
    cnt_next   = cnt;
    mode_next  = mode;
    out_next   = out_q;
    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          dreg_next  = IN;
          cnt_next   = SHAMT;
          mode_next  = ARITH;
          state_next = S_SHIFT;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        // START is deliberately not looked at here: requests during a shift are dropped.
        if (cnt != '0) begin
          dreg_next = {fill, dreg[WIDTH-1:1]};
          cnt_next  = cnt - SHW'(1);
        end else begin
          out_next   = dreg;
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign BUSY      = (state == S_SHIFT);
  assign DONE      = (state == S_DONE);
  assign OUT       = out_q;
  assign STATE_DBG = state;

endmodule
